// File: rtl/equiv_pkg.sv
// equiv_pkg: shared state encoding, LFSR constants and stimulus slice layout for equiv_stim_sched
package equiv_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
    localparam int LFSR_W = 72;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 72'h82_0000_0000_0104_0000;
    localparam int W0_LSB = 0;
    localparam int W0_W = 20;
    localparam int W1_LSB = 20;
    localparam int W1_W = 13;
    localparam int W2_LSB = 33;
    localparam int W2_W = 21;
    localparam int W3_LSB = 54;
    localparam int W3_W = 18;
endpackage

// File: rtl/equiv_lfsr72.sv
// equiv_lfsr72: 72-bit Galois LFSR with seed load; a zero seed is replaced by all-ones
module equiv_lfsr72 import equiv_pkg::*; (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic [LFSR_W-1:0] state
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= '1;
        else if (load) state <= (seed == '0) ? '1 : seed;
        else if (advance) state <= (state >> 1) ^ (state[0] ? LFSR_TAPS : '0);
endmodule

// File: rtl/equiv_stim_sched.sv
// equiv_stim_sched: drives LFSR stimulus into a duplicated DUT pair and compares their outputs
module equiv_stim_sched #(
    parameter int Y_W        = 91,
    parameter int CNT_W      = 16,
    parameter int CMP_LAT    = 1,
    parameter int STOP_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [71:0]      seed,
    input  logic [CNT_W-1:0] num_vec,
    output logic [19:0]      wire0,
    output logic [12:0]      wire1,
    output logic [20:0]      wire2,
    output logic [17:0]      wire3,
    input  logic [Y_W-1:0]   y_1,
    input  logic [Y_W-1:0]   y_2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mism_cnt,
    output logic [CNT_W-1:0] first_idx,
    output logic [Y_W-1:0]   first_y1,
    output logic [Y_W-1:0]   first_y2
);
    import equiv_pkg::*;
    state_e state, nxt;
    logic [CNT_W-1:0] num_q, idx;
    logic [CNT_W-1:0] pidx [CMP_LAT];
    logic [CMP_LAT-1:0] pv;
    logic [LFSR_W-1:0] lfsr;
    logic [3:0] dcnt;
    logic vld, aborted, accept, active, cmp, stop_mis, leave, push, advance;
    assign accept   = (state == IDLE) && start;
    assign active   = (state == RUN) || (state == DRAIN);
    assign cmp      = active && pv[CMP_LAT-1] && (y_1 != y_2);
    assign stop_mis = (STOP_FIRST != 0) && cmp;
    assign leave    = (state == RUN) && ((idx == num_q - CNT_W'(1)) || abort || stop_mis);
    assign push     = (state == RUN) && !abort && !stop_mis;
    assign advance  = (state == RUN) && !leave;
    assign busy     = active;
    assign done     = state == DONE;
    // wires stay 0 after reset until the first run issues a vector
    assign wire0 = vld ? lfsr[W0_LSB +: W0_W] : '0;
    assign wire1 = vld ? lfsr[W1_LSB +: W1_W] : '0;
    assign wire2 = vld ? lfsr[W2_LSB +: W2_W] : '0;
    assign wire3 = vld ? lfsr[W3_LSB +: W3_W] : '0;
    equiv_lfsr72 u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept && num_vec != '0),
        .seed   (seed),
        .advance(advance),
        .state  (lfsr)
    );
    always_comb begin
        nxt = state;
        if (accept) nxt = (num_vec == '0) ? DONE : RUN;
        else if (leave) nxt = DRAIN;
        else if (state == DRAIN && (abort || dcnt == 4'(CMP_LAT - 1))) nxt = DONE;
        else if (state == DONE) nxt = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            for (int i = 0; i < CMP_LAT; i++) pidx[i] <= '0;
        end else begin
            pv <= accept ? '0 : CMP_LAT'({pv, push});
            pidx[0] <= idx;
            for (int i = 1; i < CMP_LAT; i++) pidx[i] <= pidx[i-1];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            num_q     <= '0;
            idx       <= '0;
            dcnt      <= '0;
            vld       <= 1'b0;
            aborted   <= 1'b0;
            pass      <= 1'b0;
            mism_cnt  <= '0;
            first_idx <= '0;
            first_y1  <= '0;
            first_y2  <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                num_q     <= num_vec;
                idx       <= '0;
                aborted   <= 1'b0;
                pass      <= num_vec == '0;
                mism_cnt  <= '0;
                first_idx <= '0;
                first_y1  <= '0;
                first_y2  <= '0;
                vld       <= vld | (num_vec != '0);
            end else begin
                if (advance) idx <= idx + CNT_W'(1);
                dcnt <= (state == DRAIN) ? dcnt + 4'd1 : 4'd0;
                if (active && abort) aborted <= 1'b1;
                if (cmp) begin
                    mism_cnt <= (&mism_cnt) ? mism_cnt : mism_cnt + CNT_W'(1);
                    if (mism_cnt == '0) begin
                        first_idx <= pidx[CMP_LAT-1];
                        first_y1  <= y_1;
                        first_y2  <= y_2;
                    end
                end
                if (active && nxt == DONE) pass <= !(aborted || abort) && mism_cnt == '0 && !cmp;
            end
        end
    end
endmodule

// File: tb/tb_equiv_stim_sched.sv
// tb_equiv_stim_sched: directed checks of the scheduler against registered DUT-pair models
module tb_equiv_stim_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic [71:0] seed_a = '0, seed_b = '0;
    logic [15:0] num_a = '0, num_b = '0;
    logic [19:0] w0a, w0b;
    logic [12:0] w1a, w1b;
    logic [20:0] w2a, w2b;
    logic [17:0] w3a, w3b;
    logic [90:0] y1a, y2a, y1b, y2b, fy1a, fy2a, fy1b, fy2b;
    logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [15:0] mism_a, fidx_a, mism_b, fidx_b;
    logic [71:0] sa, sb, d1, d2, e1;
    logic [71:0] fs2 = '1, fs5 = '1, fs3b = '1;
    logic flip_en = 1'b0;
    int npass = 0, ntot = 0;
    assign sa = {w3a, w2a, w1a, w0a};
    assign sb = {w3b, w2b, w1b, w0b};
    // DUT pair models: A has two register stages, B has one
    always @(posedge clk) begin
        d1 <= sa;
        d2 <= d1;
        e1 <= sb;
    end
    assign y1a = {19'd0, d2};
    assign y2a = y1a ^ 91'(flip_en && (d2 == fs2 || d2 == fs5));
    assign y1b = {19'd0, e1};
    assign y2b = y1b ^ 91'(e1 == fs3b);
    equiv_stim_sched #(.Y_W(91), .CNT_W(16), .CMP_LAT(2), .STOP_FIRST(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .seed(seed_a), .num_vec(num_a),
        .wire0(w0a), .wire1(w1a), .wire2(w2a), .wire3(w3a), .y_1(y1a), .y_2(y2a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .mism_cnt(mism_a), .first_idx(fidx_a),
        .first_y1(fy1a), .first_y2(fy2a)
    );
    equiv_stim_sched #(.Y_W(91), .CNT_W(16), .CMP_LAT(1), .STOP_FIRST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .seed(seed_b), .num_vec(num_b),
        .wire0(w0b), .wire1(w1b), .wire2(w2b), .wire3(w3b), .y_1(y1b), .y_2(y2b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .mism_cnt(mism_b), .first_idx(fidx_b),
        .first_y1(fy1b), .first_y2(fy2b)
    );
    function automatic logic [71:0] step(input logic [71:0] s);
        logic [71:0] r;
        r = s >> 1;
        if (s[0]) begin
            r[71] = ~r[71];
            r[65] = ~r[65];
            r[24] = ~r[24];
            r[18] = ~r[18];
        end
        return r;
    endfunction
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    initial begin
        logic [71:0] v [4];
        logic [71:0] w [8];
        logic [71:0] u [5];
        logic [71:0] x [11];
        int n;
        v[0] = 72'd1;
        for (int k = 1; k < 4; k++) v[k] = step(v[k-1]);
        repeat (3) tick;
        chk("rst_busy", 128'(busy_a), 128'(0));
        chk("rst_done", 128'(done_a), 128'(0));
        chk("rst_pass", 128'(pass_a), 128'(0));
        chk("rst_mism", 128'(mism_a), 128'(0));
        chk("rst_wires", 128'(sa), 128'(0));
        rst_n = 1'b1;
        tick;
        // four matching vectors from seed 1
        seed_a = 72'd1; num_a = 16'd4; start_a = 1'b1;
        tick;
        start_a = 1'b0;
        chk("t1_busy", 128'(busy_a), 128'(1));
        chk("t1_vec0", 128'(sa), 128'(1));
        tick;
        chk("t1_v1_w0", 128'(w0a), 128'(20'h40000));
        chk("t1_v1_w1", 128'(w1a), 128'(13'h010));
        chk("t1_v1_w3", 128'(w3a), 128'(18'h20800));
        tick;
        chk("t1_vec2", 128'(sa), 128'(v[2]));
        tick;
        chk("t1_v3_w0", 128'(w0a), 128'(20'h10000));
        chk("t1_v3_w1", 128'(w1a), 128'(13'h004));
        chk("t1_v3_w2", 128'(w2a), 128'(0));
        chk("t1_v3_w3", 128'(w3a), 128'(18'h08200));
        tick;
        tick;
        chk("t1_done_early", 128'(done_a), 128'(0));
        tick;
        chk("t1_done", 128'(done_a), 128'(1));
        chk("t1_pass", 128'(pass_a), 128'(1));
        chk("t1_mism", 128'(mism_a), 128'(0));
        chk("t1_hold", 128'(sa), 128'(v[3]));
        chk("t1_busy_end", 128'(busy_a), 128'(0));
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        chk("t1_pulse", 128'(done_a), 128'(0));
        chk("t1_start_on_done", 128'(busy_a), 128'(0));
        tick;
        chk("t1_still_idle", 128'(busy_a), 128'(0));
        // zero-length run
        seed_a = 72'd5; num_a = 16'd0; start_a = 1'b1;
        tick;
        start_a = 1'b0;
        chk("t2_done", 128'(done_a), 128'(1));
        chk("t2_pass", 128'(pass_a), 128'(1));
        chk("t2_wires", 128'(sa), 128'(v[3]));
        tick;
        chk("t2_pulse", 128'(done_a), 128'(0));
        // mismatches injected on vectors 2 and 5
        w[0] = 72'hA5_1234_5678_9ABC_DEF0;
        for (int k = 1; k < 8; k++) w[k] = step(w[k-1]);
        fs2 = w[2]; fs5 = w[5]; flip_en = 1'b1;
        seed_a = w[0]; num_a = 16'd8; start_a = 1'b1;
        tick;
        start_a = 1'b0;
        n = 0;
        while (!done_a && n < 40) begin
            tick;
            n++;
        end
        chk("t3_done", 128'(done_a), 128'(1));
        chk("t3_lat", 128'(n), 128'(10));
        chk("t3_mism", 128'(mism_a), 128'(2));
        chk("t3_fidx", 128'(fidx_a), 128'(2));
        chk("t3_fxor", 128'(fy1a ^ fy2a), 128'(1));
        chk("t3_fy1", 128'(fy1a), 128'({19'd0, w[2]}));
        chk("t3_pass", 128'(pass_a), 128'(0));
        chk("t3_last", 128'(sa), 128'(w[7]));
        flip_en = 1'b0;
        // stop on first mismatch at vector 3 of 100
        u[0] = 72'h0F_0000_1234_0000_0077;
        for (int k = 1; k < 5; k++) u[k] = step(u[k-1]);
        fs3b = u[3];
        seed_b = u[0]; num_b = 16'd100; start_b = 1'b1;
        tick;
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 20) begin
            tick;
            n++;
        end
        chk("t4_done", 128'(done_b), 128'(1));
        chk("t4_lat", 128'(n), 128'(6));
        chk("t4_mism", 128'(mism_b), 128'(1));
        chk("t4_fidx", 128'(fidx_b), 128'(3));
        chk("t4_fxor", 128'(fy1b ^ fy2b), 128'(1));
        chk("t4_pass", 128'(pass_b), 128'(0));
        chk("t4_last", 128'(sb), 128'(u[4]));
        // abort at vector 10 of 50, with a competing start
        x[0] = 72'h3C;
        for (int k = 1; k < 11; k++) x[k] = step(x[k-1]);
        seed_a = x[0]; num_a = 16'd50; start_a = 1'b1;
        tick;
        start_a = 1'b0;
        repeat (10) tick;
        chk("t5_vec10", 128'(sa), 128'(x[10]));
        abort_a = 1'b1; start_a = 1'b1; seed_a = 72'h99;
        tick;
        abort_a = 1'b0; start_a = 1'b0;
        chk("t5_busy_drain", 128'(busy_a), 128'(1));
        n = 1;
        while (!done_a && n < 8) begin
            tick;
            n++;
        end
        chk("t5_done", 128'(done_a), 128'(1));
        chk("t5_lat", 128'(n), 128'(3));
        chk("t5_pass", 128'(pass_a), 128'(0));
        chk("t5_mism", 128'(mism_a), 128'(0));
        chk("t5_hold", 128'(sa), 128'(x[10]));
        tick;
        chk("t5_no_restart", 128'(busy_a), 128'(0));
        // zero seed behaves as all-ones
        seed_a = '0; num_a = 16'd3; start_a = 1'b1;
        tick;
        start_a = 1'b0;
        chk("t6_seed0_v0", 128'(sa), 128'({72{1'b1}}));
        tick;
        chk("t6_seed0_v1", 128'(sa), 128'(step({72{1'b1}})));
        n = 0;
        while (!done_a && n < 10) begin
            tick;
            n++;
        end
        chk("t6_done", 128'(done_a), 128'(1));
        tick;
        // reset in the middle of a run that already holds a mismatch
        flip_en = 1'b1;
        seed_a = w[0]; num_a = 16'd8; start_a = 1'b1;
        tick;
        start_a = 1'b0;
        repeat (5) tick;
        chk("t7_mism_pre", 128'(mism_a), 128'(1));
        chk("t7_busy_pre", 128'(busy_a), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("t7_busy", 128'(busy_a), 128'(0));
        chk("t7_mism", 128'(mism_a), 128'(0));
        chk("t7_fidx", 128'(fidx_a), 128'(0));
        chk("t7_fy1", 128'(fy1a), 128'(0));
        chk("t7_wires", 128'(sa), 128'(0));
        chk("t7_b_mism", 128'(mism_b), 128'(0));
        tick;
        chk("t7_done_rst", 128'(done_a), 128'(0));
        rst_n = 1'b1;
        flip_en = 1'b0;
        tick;
        chk("t7_done_after", 128'(done_a), 128'(0));
        chk("t7_idle", 128'(busy_a), 128'(0));
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
